// File: rtl/alarm_annunciator.sv
// alarm_annunciator: debounces the decoder ALARM line and latches the event.
// While latched it drives a blinking siren and a steady lamp until the event is
// acknowledged and the condition clears. It then holds off before re-arming.
// Qualified events are counted and the count saturates at 255.
module alarm_annunciator #(
  parameter int DEBOUNCE   = 4,
  parameter int BLINK_HALF = 8,
  parameter int HOLDOFF    = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ALARM,
  input  logic       ARM,
  input  logic       ACK,
  output logic       SIREN,
  output logic       LAMP,
  output logic       LATCHED,
  output logic [7:0] EVENT_CNT
);

  typedef enum logic [2:0] {
    S_DISARMED, S_IDLE, S_QUALIFY, S_SOUNDING, S_ACKED, S_HOLDOFF
  } state_t;

  // Terminal counts: each counter hits its *_LAST value on the cycle that ends its phase.
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [7:0] BL_LAST  = 8'(BLINK_HALF - 1);
  localparam logic [7:0] HO_LAST  = 8'(HOLDOFF - 1);

  state_t     state;
  logic [7:0] qcnt, bcnt, hcnt;

  // Single-process FSM; outputs are registered and updated on each transition.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_DISARMED;
      qcnt      <= '0;
      bcnt      <= '0;
      hcnt      <= '0;
      SIREN     <= 1'b0;
      LAMP      <= 1'b0;
      LATCHED   <= 1'b0;
      EVENT_CNT <= '0;
    end else begin
      case (state)
        S_DISARMED: if (ARM) state <= S_IDLE;
        S_IDLE: begin
          if (!ARM) state <= S_DISARMED;
          else if (ALARM) begin
            state <= S_QUALIFY;
            qcnt  <= 8'd1;
          end
        end
        S_QUALIFY: begin
          if (!ARM) begin
            // Disarm wins over a pending qualification; nothing is counted.
            state <= S_DISARMED;
            qcnt  <= '0;
          end else if (!ALARM) begin
            state <= S_IDLE;
            qcnt  <= '0;
          end else if (qcnt == DEB_LAST) begin
            state   <= S_SOUNDING;
            qcnt    <= '0;
            bcnt    <= '0;
            SIREN   <= 1'b1;
            LAMP    <= 1'b1;
            LATCHED <= 1'b1;
            if (EVENT_CNT != 8'hFF) EVENT_CNT <= EVENT_CNT + 8'd1;
          end else qcnt <= qcnt + 8'd1;
        end
        S_SOUNDING: begin
          // ARM is deliberately not examined: a latched event cannot be disarmed away.
          if (ACK) begin
            state <= S_ACKED;
            SIREN <= 1'b0;
            bcnt  <= '0;
          end else if (bcnt == BL_LAST) begin
            bcnt  <= '0;
            SIREN <= ~SIREN;
          end else bcnt <= bcnt + 8'd1;
        end
        S_ACKED: begin
          if (!ALARM) begin
            state   <= S_HOLDOFF;
            hcnt    <= '0;
            LAMP    <= 1'b0;
            LATCHED <= 1'b0;
          end
        end
        S_HOLDOFF: begin
          if (hcnt == HO_LAST) begin
            hcnt  <= '0;
            state <= ARM ? S_IDLE : S_DISARMED;
          end else hcnt <= hcnt + 8'd1;
        end
        default: state <= S_DISARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_annunciator.sv
// Bench for alarm_annunciator: directed steps followed by randomized traffic.
// Every cycle is compared against an event-level reference model.
module tb_alarm_annunciator;
  localparam int DEB = 4;
  localparam int BH  = 8;
  localparam int HO  = 16;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ALARM = 1'b0, ARM = 1'b0, ACK = 1'b0;
  logic       SIREN, LAMP, LATCHED;
  logic [7:0] EVENT_CNT;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  // m_armed : armed and watching for alarms.
  // m_run   : consecutive high samples seen so far.
  // m_latched / m_acked : the event is latched / has been acknowledged.
  // m_age   : cycles spent sounding.
  // m_hold  : hold-off cycles remaining.
  bit m_armed, m_latched, m_acked;
  int m_run, m_age, m_hold, m_cnt;

  alarm_annunciator #(.DEBOUNCE(DEB), .BLINK_HALF(BH), .HOLDOFF(HO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ALARM(ALARM), .ARM(ARM), .ACK(ACK),
    .SIREN(SIREN), .LAMP(LAMP), .LATCHED(LATCHED), .EVENT_CNT(EVENT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_armed = 0; m_latched = 0; m_acked = 0;
    m_run = 0; m_age = 0; m_hold = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit arm, input bit alarm, input bit ack);
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_armed = arm;
    end else if (m_latched) begin
      if (!m_acked) begin
        if (ack) m_acked = 1; else m_age++;
      end else if (!alarm) begin
        m_latched = 0; m_acked = 0; m_hold = HO;
      end
    end else if (!m_armed) begin
      m_armed = arm; m_run = 0;
    end else if (!arm) begin
      m_armed = 0; m_run = 0;
    end else if (alarm) begin
      m_run++;
      if (m_run == DEB) begin
        m_latched = 1; m_acked = 0; m_age = 0; m_run = 0;
        if (m_cnt < 255) m_cnt++;
      end
    end else m_run = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    bit exp_siren;
    exp_siren = m_latched && !m_acked && (((m_age / BH) % 2) == 0);
    chk("siren",   {7'd0, SIREN},   {7'd0, exp_siren});
    chk("lamp",    {7'd0, LAMP},    {7'd0, m_latched});
    chk("latched", {7'd0, LATCHED}, {7'd0, m_latched});
    chk("evcnt",   EVENT_CNT,       8'(m_cnt));
  endtask

  // Apply inputs, take one rising edge, then compare just after it.
  task automatic drive(input bit arm, input bit alarm, input bit ack);
    ARM = arm; ALARM = alarm; ACK = ack;
    @(posedge CLK);
    model_step(arm, alarm, ack);
    #1;
    chk_model();
  endtask

  task automatic drive_n(input int n, input bit arm, input bit alarm, input bit ack);
    for (int i = 0; i < n; i++) drive(arm, alarm, ack);
  endtask

  initial begin
    bit al;
    model_reset();
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_siren", {7'd0, SIREN}, 8'd0);
    chk("rst_lamp", {7'd0, LAMP}, 8'd0);
    chk("rst_cnt", EVENT_CNT, 8'd0);
    @(negedge CLK); RESET_N = 1'b1;

    // Debounce pass
    drive(1, 0, 0);
    drive_n(3, 1, 1, 0);
    chk("deb_early", {7'd0, LATCHED}, 8'd0);
    drive(1, 1, 0);
    chk("deb_siren", {7'd0, SIREN}, 8'd1);
    chk("deb_lamp", {7'd0, LAMP}, 8'd1);
    chk("deb_latched", {7'd0, LATCHED}, 8'd1);
    chk("deb_cnt", EVENT_CNT, 8'd1);

    // Blink and ack mid-high
    drive_n(8, 1, 1, 0);
    chk("blink_low", {7'd0, SIREN}, 8'd0);
    drive_n(8, 1, 1, 0);
    chk("blink_high", {7'd0, SIREN}, 8'd1);
    drive_n(3, 1, 1, 0);
    drive(1, 1, 1);
    chk("ack_siren", {7'd0, SIREN}, 8'd0);
    chk("ack_lamp", {7'd0, LAMP}, 8'd1);
    drive(1, 1, 0);

    // Clear, hold-off, and an alarm burst that falls inside the hold-off window
    drive(1, 0, 0);
    chk("clr_lamp", {7'd0, LAMP}, 8'd0);
    drive_n(4, 1, 0, 0);
    drive_n(10, 1, 1, 0);
    drive_n(2, 1, 0, 0);
    chk("hold_noevt", EVENT_CNT, 8'd1);
    drive_n(3, 1, 1, 0);
    chk("rearm_early", {7'd0, LATCHED}, 8'd0);
    drive(1, 1, 0);
    chk("rearm_evt", EVENT_CNT, 8'd2);
    drive(1, 1, 1);
    drive(1, 0, 0);
    drive_n(HO, 1, 0, 0);

    // Glitch reject
    drive_n(3, 1, 1, 0);
    drive(1, 0, 0);
    drive_n(3, 1, 1, 0);
    chk("glitch_early", {7'd0, LATCHED}, 8'd0);
    drive(1, 1, 0);
    chk("glitch_latch", {7'd0, LATCHED}, 8'd1);
    chk("glitch_cnt", EVENT_CNT, 8'd3);
    drive(1, 0, 1);
    drive(1, 0, 0);
    drive_n(HO, 1, 0, 0);

    // Disarm priority in QUALIFY
    drive_n(2, 1, 1, 0);
    drive(0, 1, 0);
    chk("disarm_latch", {7'd0, LATCHED}, 8'd0);
    chk("disarm_cnt", EVENT_CNT, 8'd3);
    drive_n(5, 0, 1, 0);
    drive(1, 0, 0);

    // Saturation
    for (int e = 0; e < 256; e++) begin
      drive_n(DEB, 1, 1, 0);
      drive(1, 0, 1);
      drive(1, 0, 0);
      drive_n(HO, 1, 0, 0);
    end
    chk("sat_cnt", EVENT_CNT, 8'd255);

    // Asynchronous reset while sounding
    drive_n(DEB, 1, 1, 0);
    chk("pre_rst_latch", {7'd0, LATCHED}, 8'd1);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("arst_siren", {7'd0, SIREN}, 8'd0);
    chk("arst_lamp", {7'd0, LAMP}, 8'd0);
    chk("arst_latched", {7'd0, LATCHED}, 8'd0);
    chk("arst_cnt", EVENT_CNT, 8'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    model_reset();

    // Randomized traffic
    al = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) al = ~al;
      drive($urandom_range(0, 99) < 95, al, $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
